// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic-phase sequencer.
// The RST state exists only when PLL_PHASE_CTRL_LOCKMON_EN is defined.
package pll_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    SETTLE   = 3'd4,
    WAITLOCK = 3'd5,
    DONE     = 3'd6
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
    , RST    = 3'd7
`endif
  } state_t;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  // Lock-loss monitor: consecutive low cycles before acting, and PLL reset length.
  localparam int LOCKLOSS_CYC = 8;
  localparam int LOCKRST_CYC  = 16;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Double-flop synchroniser for the PLL LOCK pin plus a saturating run counter
// that flags lock_lost after LOCKLOSS_CYC consecutive low synchronised samples.
module pll_lock_sync
  import pll_phase_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic locked,
  output logic lock_s,
  output logic lock_lost
);

  localparam int RUN_W = $clog2(LOCKLOSS_CYC + 1);

  logic             meta;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
      run    <= '0;
    end else begin
      meta   <= locked;
      lock_s <= meta;
      if (lock_s)
        run <= '0;
      else if (run != RUN_W'(LOCKLOSS_CYC))
        run <= run + 1'b1;
    end
  end

  assign lock_lost = (run == RUN_W'(LOCKLOSS_CYC));

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP pulses for the ECP5 EHXPLLL and waits for lock.
// Define PLL_PHASE_CTRL_LOCKMON_EN to add the idle lock-loss monitor driving pll_rst.
module pll_phase_ctrl
  import pll_phase_ctrl_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TO    = 4096
) (
  input  logic              clock,
  input  logic              reset,
  // Handshake: a request transfers on a clock edge where req_valid and req_ready are
  // both high; req_ready is high only in IDLE, and fields are captured at that edge.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              done,
  output logic              timeout,
  input  logic              pll_locked,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_rst,
  output logic              busy,
  output state_t            state
);

  localparam int TMR_MAX = max_of(max_of(SETUP_CYC, PULSE_CYC),
                                  max_of(max_of(GAP_CYC, SETTLE_CYC), LOCKRST_CYC));
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int LOCK_W  = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

  logic              ready_en;
  logic [TMR_W-1:0]  timer;
  logic [STEP_W-1:0] steps_left;
  logic [LOCK_W-1:0] lock_cnt;
  logic              lock_s;

`ifdef PLL_PHASE_CTRL_LOCKMON_EN
  logic lock_lost;
  logic mon_flow;

  pll_lock_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .locked    (pll_locked),
    .lock_s    (lock_s),
    .lock_lost (lock_lost)
  );

  // Lock loss wins over a pending request so a request is never half-accepted.
  assign req_ready = ready_en && (state == IDLE) && !lock_lost;
`else
  logic lock_lost_unused;

  pll_lock_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .locked    (pll_locked),
    .lock_s    (lock_s),
    .lock_lost (lock_lost_unused)
  );

  assign req_ready = ready_en && (state == IDLE);
  assign pll_rst   = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ready_en      <= 1'b0;
      timer         <= '0;
      steps_left    <= '0;
      lock_cnt      <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      pll_phasesel  <= SEL_CLKOP;
      pll_phasedir  <= 1'b1;
      pll_phasestep <= 1'b1;
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
      pll_rst       <= 1'b0;
      mon_flow      <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
          if (lock_lost) begin
            state    <= RST;
            pll_rst  <= 1'b1;
            mon_flow <= 1'b1;
            timer    <= TMR_W'(LOCKRST_CYC - 1);
          end
`endif
          if (req_valid && req_ready) begin
            pll_phasesel <= req_sel;
            pll_phasedir <= req_dir;
            steps_left   <= req_steps;
            timeout      <= 1'b0;
            if (req_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
              timer <= TMR_W'(SETUP_CYC - 1);
            end
          end
        end
        SETUP: begin
          if (timer == '0) begin
            state         <= PULSE;
            pll_phasestep <= 1'b0;
            timer         <= TMR_W'(PULSE_CYC - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            pll_phasestep <= 1'b1;
            steps_left    <= steps_left - 1'b1;
            if (steps_left == STEP_W'(1)) begin
              state <= SETTLE;
              timer <= TMR_W'(SETTLE_CYC - 1);
            end else begin
              state <= GAP;
              timer <= TMR_W'(GAP_CYC - 1);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (timer == '0) begin
            state         <= PULSE;
            pll_phasestep <= 1'b0;
            timer         <= TMR_W'(PULSE_CYC - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state    <= WAITLOCK;
            lock_cnt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        WAITLOCK: begin
          // A lock seen on the final count still counts as locked, not timed out.
          if (lock_s || (lock_cnt == LOCK_W'(LOCK_TO - 1))) begin
            if (!lock_s)
              timeout <= 1'b1;
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
            if (mon_flow) begin
              state    <= IDLE;
              mon_flow <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
`ifdef PLL_PHASE_CTRL_LOCKMON_EN
        RST: begin
          if (timer == '0) begin
            state    <= WAITLOCK;
            pll_rst  <= 1'b0;
            lock_cnt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: vector table of requests plus reset and lock-monitor sequences.
// The lock-monitor sequence runs only when PLL_PHASE_CTRL_LOCKMON_EN is defined.
module tb_pll_phase_ctrl;
  import pll_phase_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       done, timeout;
  logic       pll_locked = 1'b1;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir, pll_phasestep, pll_rst, busy;
  state_t     state;

  int checks = 0;
  int errors = 0;

  pll_phase_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_dir       (req_dir),
    .req_steps     (req_steps),
    .done          (done),
    .timeout       (timeout),
    .pll_locked    (pll_locked),
    .pll_phasesel  (pll_phasesel),
    .pll_phasedir  (pll_phasedir),
    .pll_phasestep (pll_phasestep),
    .pll_rst       (pll_rst),
    .busy          (busy),
    .state         (state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic [7:0] steps;
    logic       locked;
    int         exp_lat;
    int         exp_low;
    int         exp_pulses;
    logic       exp_to;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   cyc, low, pulses, stable_bad, ready_bad, timing_bad, n, rst_cnt;
    logic got_done, prev, done_seen;

    vecs[0] = '{2'd1, 1'b1, 8'd1, 1'b1, 21,   2,  1, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 8'd3, 1'b1, 33,   6,  3, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 8'd0, 1'b1, 0,    0,  0, 1'b0};
    vecs[3] = '{2'd3, 1'b1, 8'd1, 1'b0, 4116, 2,  1, 1'b1};
    vecs[4] = '{2'd1, 1'b0, 8'd2, 1'b1, 27,   4,  2, 1'b0};
    vecs[5] = '{2'd2, 1'b0, 8'd5, 1'b1, 45,   10, 5, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 8'd0, 1'b1, 0,    0,  0, 1'b0};

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_step", {31'd0, pll_phasestep}, 32'd1);
    check("rst_dir", {31'd0, pll_phasedir}, 32'd1);
    check("rst_sel", {30'd0, pll_phasesel}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_pllrst", {31'd0, pll_rst}, 32'd0);
    check("rst_state", {29'd0, state}, {29'd0, IDLE});
    reset = 1'b0;
    #1;
    check("ready_pre_edge", {31'd0, req_ready}, 32'd0);
    tick();
    check("ready_post_rel", {31'd0, req_ready}, 32'd1);

    // Request vectors
    for (int i = 0; i < 7; i++) begin
      pll_locked = vecs[i].locked;
      repeat (4) tick();
      wait_ready();
      req_sel   = vecs[i].sel;
      req_dir   = vecs[i].dir;
      req_steps = vecs[i].steps;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_sel   = ~vecs[i].sel;
      req_dir   = ~vecs[i].dir;
      req_steps = 8'hff;
      check("timeout_clr", {31'd0, timeout}, 32'd0);
      cyc = 0; low = 0; pulses = 0; stable_bad = 0; ready_bad = 0; timing_bad = 0;
      prev = 1'b1; got_done = 1'b0;
      while (cyc <= vecs[i].exp_lat + 20 && !got_done) begin
        if (pll_phasesel !== vecs[i].sel || pll_phasedir !== vecs[i].dir) stable_bad++;
        if (req_ready !== 1'b0) ready_bad++;
        if (pll_phasestep === 1'b0) begin
          low++;
          if (prev === 1'b1) begin
            if (cyc != 2 + pulses * 6) timing_bad++;
            pulses++;
          end
        end
        prev = pll_phasestep;
        if (done === 1'b1) got_done = 1'b1;
        else begin
          tick();
          cyc++;
        end
      end
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("latency", cyc, vecs[i].exp_lat);
      check("low_cycles", low, vecs[i].exp_low);
      check("pulse_count", pulses, vecs[i].exp_pulses);
      check("pulse_timing", timing_bad, 0);
      check("sel_dir_stable", stable_bad, 0);
      check("ready_low_busy", ready_bad, 0);
      check("timeout_at_done", {31'd0, timeout}, {31'd0, vecs[i].exp_to});
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("timeout_sticky", {31'd0, timeout}, {31'd0, vecs[i].exp_to});
      check("step_idle_high", {31'd0, pll_phasestep}, 32'd1);
      if (vecs[i].locked) check("ready_after_done", {31'd0, req_ready}, 32'd1);
    end

    // Reset during a step pulse
    pll_locked = 1'b1;
    repeat (4) tick();
    wait_ready();
    req_sel = 2'd2; req_dir = 1'b0; req_steps = 8'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (pll_phasestep !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check("mid_pulse_low", {31'd0, pll_phasestep}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_step", {31'd0, pll_phasestep}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rel_ready0", {31'd0, req_ready}, 32'd0);
    tick();
    check("mid_rel_ready1", {31'd0, req_ready}, 32'd1);
    check("mid_rel_done", {31'd0, done}, 32'd0);

`ifdef PLL_PHASE_CTRL_LOCKMON_EN
    // Lock loss in IDLE pulses pll_rst, then returns to IDLE without done
    repeat (4) tick();
    pll_locked = 1'b0;
    done_seen = 1'b0; ready_bad = 0; rst_cnt = 0;
    n = 0;
    while (pll_rst !== 1'b1 && n < 40) begin
      if (done === 1'b1) done_seen = 1'b1;
      tick();
      n++;
    end
    check("mon_rst_rise", {31'd0, pll_rst}, 32'd1);
    n = 0;
    while (pll_rst === 1'b1 && n < 40) begin
      rst_cnt++;
      if (req_ready !== 1'b0) ready_bad++;
      tick();
      n++;
    end
    pll_locked = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      if (done === 1'b1) done_seen = 1'b1;
      if (req_ready !== 1'b0) ready_bad++;
      tick();
      n++;
    end
    check("mon_rst_len", rst_cnt, 16);
    check("mon_ready_low", ready_bad, 0);
    check("mon_no_done", {31'd0, done_seen}, 32'd0);
    check("mon_idle", {31'd0, busy}, 32'd0);
    check("mon_ready_back", {31'd0, req_ready}, 32'd1);
`else
    done_seen = 1'b0;
    rst_cnt = 0;
    if (done_seen) rst_cnt = 1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
